key_debounce_pulse: RTL

Input-side counterpart of the board LED timer. Turns a raw, bouncy, asynchronous, low-active push-button into clean single-cycle event pulses and a debounced level. Sits between the board key pins and the TSN chip control logic, for example for a manual reset request or a mode/test trigger. Output pulses may drive the LED on-time block directly.

---
 rtl/key_debounce_pulse_pkg.sv | 17 +
 rtl/key_debounce_pulse_key_sync.sv | 28 ++
 rtl/key_debounce_pulse.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/key_debounce_pulse_pkg.sv
// Shared definitions for the key debouncer: FSM state encoding, key
// polarity constants and synchronizer depth.
package key_debounce_pulse_pkg;

  typedef enum logic [1:0] {
    IDLE_S        = 2'd0,
    PRESS_CHK_S   = 2'd1,
    PRESSED_S     = 2'd2,
    RELEASE_CHK_S = 2'd3
  } state_t;

  localparam logic KEY_PRESSED  = 1'b0;
  localparam logic KEY_RELEASED = 1'b1;

  localparam int unsigned SYNC_DEPTH = 2;

endpackage

// File: rtl/key_debounce_pulse_key_sync.sv
// key_sync: multi-flop synchronizer for asynchronous board inputs.
// Every stage resets to RESET_VALUE (released level for low-active keys).
module key_sync
  import key_debounce_pulse_pkg::*;
#(
  parameter int unsigned DEPTH       = SYNC_DEPTH,
  parameter logic        RESET_VALUE = KEY_RELEASED
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] stage;

  // Shift the raw input through the synchronizer chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage <= {DEPTH{RESET_VALUE}};
    end else begin
      stage <= {stage[DEPTH-2:0], d};
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/key_debounce_pulse.sv
// key_debounce_pulse: turns a bouncy low-active push-button into a debounced
// level plus single-cycle press/release pulses.
// Optional long-press event built when LONG_PRESS_EN is defined; otherwise
// o_long_press_pulse is tied low.
module key_debounce_pulse
  import key_debounce_pulse_pkg::*;
#(
  parameter logic [31:0] DEBOUNCE_TIME   = 32'd1_250_000,
  parameter logic [31:0] LONG_PRESS_TIME = 32'd250_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key,
  output logic o_key_level,
  output logic o_press_pulse,
  output logic o_release_pulse,
  output logic o_long_press_pulse
);

  localparam logic [31:0] DEB_LAST = DEBOUNCE_TIME - 32'd1;

  if (DEBOUNCE_TIME < 32'd1) begin : g_bad_debounce
    $error("DEBOUNCE_TIME must be at least 1");
  end
  if (LONG_PRESS_TIME < 32'd2) begin : g_bad_long_press
    $error("LONG_PRESS_TIME must be greater than 1");
  end

  logic        key_s;
  state_t      state, state_nxt;
  logic [31:0] cnt, cnt_nxt;
  logic        key_level, level_nxt;
  logic        press_pulse, press_nxt;
  logic        release_pulse, release_nxt;

  key_sync #(
    .DEPTH       (SYNC_DEPTH),
    .RESET_VALUE (KEY_RELEASED)
  ) u_key_sync (
    .clk (i_clk),
    .rst (i_rst),
    .d   (i_key),
    .q   (key_s)
  );

  // FSM state, debounce counter and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= IDLE_S;
      cnt           <= '0;
      key_level     <= KEY_RELEASED;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      key_level     <= level_nxt;
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
    end
  end

  // Next-state, counter and pulse decode.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    level_nxt   = key_level;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    case (state)
      IDLE_S: begin
        if (key_s == KEY_PRESSED) begin
          state_nxt = PRESS_CHK_S;
          cnt_nxt   = '0;
        end
      end
      PRESS_CHK_S: begin
        if (key_s == KEY_RELEASED) begin
          state_nxt = IDLE_S;
          cnt_nxt   = '0;
        end else if (cnt == DEB_LAST) begin
          state_nxt = PRESSED_S;
          cnt_nxt   = '0;
          level_nxt = KEY_PRESSED;
          press_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 32'd1;
        end
      end
      PRESSED_S: begin
        if (key_s == KEY_RELEASED) begin
          state_nxt = RELEASE_CHK_S;
          cnt_nxt   = '0;
        end
      end
      RELEASE_CHK_S: begin
        if (key_s == KEY_PRESSED) begin
          state_nxt = PRESSED_S;
          cnt_nxt   = '0;
        end else if (cnt == DEB_LAST) begin
          state_nxt   = IDLE_S;
          cnt_nxt     = '0;
          level_nxt   = KEY_RELEASED;
          release_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 32'd1;
        end
      end
      default: begin
        state_nxt = IDLE_S;
        cnt_nxt   = '0;
        level_nxt = KEY_RELEASED;
      end
    endcase
  end

  assign o_key_level     = key_level;
  assign o_press_pulse   = press_pulse;
  assign o_release_pulse = release_pulse;

`ifdef LONG_PRESS_EN
  localparam logic [31:0] LONG_LAST = LONG_PRESS_TIME - 32'd1;

  logic [31:0] long_cnt;
  logic        long_pulse;

  // Long-press counter: runs in PRESSED_S, holds in RELEASE_CHK_S so a
  // release bounce keeps the accumulated time, and parks at LONG_PRESS_TIME
  // after firing so one press yields at most one event.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      long_cnt   <= '0;
      long_pulse <= 1'b0;
    end else begin
      long_pulse <= 1'b0;
      if (state == PRESS_CHK_S && state_nxt == PRESSED_S) begin
        long_cnt <= '0;
      end else if (state_nxt == IDLE_S) begin
        long_cnt <= '0;
      end else if (state == PRESSED_S) begin
        if (long_cnt == LONG_LAST) begin
          long_pulse <= 1'b1;
          long_cnt   <= LONG_PRESS_TIME;
        end else if (long_cnt < LONG_LAST) begin
          long_cnt <= long_cnt + 32'd1;
        end
      end
    end
  end

  assign o_long_press_pulse = long_pulse;
`else
  assign o_long_press_pulse = 1'b0;
`endif

endmodule
